// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- handshake bundle between the IF stage, the fetch queue
// and the ID stage.
//   Producer side (IF -> queue):  i_in_valid, i_in_pc, i_in_instr,
//                                 i_in_pred_taken, o_in_ready (back to IF)
//   Consumer side (queue -> ID):  o_out_valid, o_out_pc, o_out_instr,
//                                 o_out_pred_taken, i_out_ready (back from ID)
// Signal names are written from the queue's point of view, so i_* are
// queue inputs and o_* are queue outputs.
//   modport slave  : the fetch queue itself
//   modport master : the surrounding pipeline (IF + ID) or a testbench
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            i_in_valid;
    logic [XLEN-1:0] i_in_pc;
    logic [31:0]     i_in_instr;
    logic            i_in_pred_taken;
    logic            o_in_ready;

    logic            o_out_valid;
    logic [XLEN-1:0] o_out_pc;
    logic [31:0]     o_out_instr;
    logic            o_out_pred_taken;
    logic            i_out_ready;

    modport slave (
        input  i_in_valid, i_in_pc, i_in_instr, i_in_pred_taken, i_out_ready,
        output o_in_ready, o_out_valid, o_out_pc, o_out_instr, o_out_pred_taken
    );

    modport master (
        output i_in_valid, i_in_pc, i_in_instr, i_in_pred_taken, i_out_ready,
        input  o_in_ready, o_out_valid, o_out_pc, o_out_instr, o_out_pred_taken
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue -- small FIFO decoupling instruction fetch from decode.
// Entries carry {pc, instr, pred_taken}. A flush (redirect from a later
// stage) empties the queue and raises o_bubble for the following cycle.
// Ports:
//   i_clk     : rising-edge clock
//   i_reset   : synchronous, active-low reset
//   i_flush   : discard all queued entries
//   bus       : fetch_queue_if.slave (push side from IF, pop side to ID)
//   o_count   : number of valid entries
//   o_bubble  : one-cycle pulse after each flush cycle
module fetch_queue #(
    parameter int          XLEN      = 32,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_flush,
    fetch_queue_if.slave               bus,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_bubble
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Storage: no reset needed, validity is tracked by the count.
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic            pred_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             bubble_q, bubble_d;

    logic in_ready;
    logic out_valid;
    logic push;
    logic pop;

    // Ready depends on state only, so IF never sees a combinational path
    // from ID's ready or from the flush request.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.i_in_valid && in_ready;
    assign pop       = out_valid && bus.i_out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        bubble_d = 1'b0;
        if (i_flush) begin
            // Redirect wins: drop everything, including this cycle's push/pop.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            bubble_d = 1'b1;
        end else begin
            // Pointers are PTR_W bits wide, so +1 wraps modulo DEPTH.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bubble_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bubble_q <= bubble_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && i_reset && !i_flush) begin
            pc_mem[wr_ptr_q]    <= bus.i_in_pc;
            instr_mem[wr_ptr_q] <= bus.i_in_instr;
            pred_mem[wr_ptr_q]  <= bus.i_in_pred_taken;
        end
    end

    // Head is read from registered state only, so a push becomes visible
    // the cycle after it is written. Empty queue presents a NOP.
    assign bus.o_in_ready       = in_ready;
    assign bus.o_out_valid      = out_valid;
    assign bus.o_out_pc         = out_valid ? pc_mem[rd_ptr_q]    : '0;
    assign bus.o_out_instr      = out_valid ? instr_mem[rd_ptr_q] : NOP_INSTR;
    assign bus.o_out_pred_taken = out_valid ? pred_mem[rd_ptr_q]  : 1'b0;
    assign o_count              = count_q;
    assign o_bubble             = bubble_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- directed test of fetch_queue (DEPTH=4, XLEN=32).
// Inputs change 1 ns after a rising edge; outputs are checked at the same
// point, i.e. they reflect the state loaded by that edge.
module tb_fetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [2:0] count;
    logic       bubble;

    int vectors;
    int miscompares;

    fetch_queue_if #(.XLEN(XLEN)) bus ();

    fetch_queue #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .NOP_INSTR(NOP)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .i_flush (flush),
        .bus     (bus),
        .o_count (count),
        .o_bubble(bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-24s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_push(input logic v, input logic [31:0] pc, input logic pred);
        bus.i_in_valid      = v;
        bus.i_in_pc         = pc;
        bus.i_in_instr      = 32'hA000_0000 | pc;
        bus.i_in_pred_taken = pred;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        drive_push(1'b0, 32'h0, 1'b0);
        bus.i_out_ready = 1'b0;

        // ---- reset state
        step();
        step();
        rst_n = 1'b1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(bus.o_out_valid), 64'd0);
        check("rst_out_pc", 64'(bus.o_out_pc), 64'd0);
        check("rst_out_instr", 64'(bus.o_out_instr), 64'(NOP));
        check("rst_pred", 64'(bus.o_out_pred_taken), 64'd0);
        check("rst_bubble", 64'(bubble), 64'd0);
        check("rst_in_ready", 64'(bus.o_in_ready), 64'd1);

        // ---- fill: push 0x0,0x4,0x8,0xC with ID stalled
        for (int k = 0; k < 4; k++) begin
            drive_push(1'b1, 32'(4 * k), 1'b0);
            step();
            check($sformatf("fill_count_%0d", k), 64'(count), 64'(k + 1));
        end
        check("full_in_ready", 64'(bus.o_in_ready), 64'd0);
        check("full_head_pc", 64'(bus.o_out_pc), 64'h0);
        drive_push(1'b1, 32'h10, 1'b0);   // fifth push must be ignored
        step();
        check("full_ignore_count", 64'(count), 64'd4);
        drive_push(1'b0, 32'h0, 1'b0);

        // ---- drain
        bus.i_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_valid_%0d", k), 64'(bus.o_out_valid), 64'd1);
            check($sformatf("drain_pc_%0d", k), 64'(bus.o_out_pc), 64'(4 * k));
            check($sformatf("drain_instr_%0d", k), 64'(bus.o_out_instr), 64'(32'hA000_0000 | (4 * k)));
            step();
        end
        check("empty_valid", 64'(bus.o_out_valid), 64'd0);
        check("empty_instr", 64'(bus.o_out_instr), 64'(NOP));
        check("empty_pc", 64'(bus.o_out_pc), 64'd0);
        check("empty_count", 64'(count), 64'd0);
        step();   // pop request while empty must not move anything
        check("empty_pop_count", 64'(count), 64'd0);

        // ---- wrap / throughput: push and pop every cycle
        for (int k = 0; k < 12; k++) begin
            drive_push(1'b1, 32'h100 + 32'(4 * k), 1'b0);
            step();
            check($sformatf("wrap_count_%0d", k), 64'(count), 64'd1);
            check($sformatf("wrap_pc_%0d", k), 64'(bus.o_out_pc), 64'(32'h100 + 4 * k));
        end
        drive_push(1'b0, 32'h0, 1'b0);
        step();
        check("wrap_end_count", 64'(count), 64'd0);

        // ---- full plus simultaneous pop
        bus.i_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_push(1'b1, 32'h200 + 32'(4 * k), 1'b0);
            step();
        end
        check("fp_full_count", 64'(count), 64'd4);
        drive_push(1'b1, 32'h40, 1'b0);
        bus.i_out_ready = 1'b1;
        step();
        check("fp_count_after_pop", 64'(count), 64'd3);
        check("fp_head_pc", 64'(bus.o_out_pc), 64'h204);
        bus.i_out_ready = 1'b0;
        step();
        check("fp_push_accept", 64'(count), 64'd4);
        drive_push(1'b0, 32'h0, 1'b0);
        bus.i_out_ready = 1'b1;
        check("fp_order_0", 64'(bus.o_out_pc), 64'h204);
        step();
        check("fp_order_1", 64'(bus.o_out_pc), 64'h208);
        step();
        check("fp_order_2", 64'(bus.o_out_pc), 64'h20C);
        step();
        check("fp_order_3", 64'(bus.o_out_pc), 64'h40);
        step();
        check("fp_drained", 64'(count), 64'd0);

        // ---- flush with push and pop in the same cycle
        bus.i_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_push(1'b1, 32'h300 + 32'(4 * k), 1'b0);
            step();
        end
        check("fl_pre_count", 64'(count), 64'd3);
        flush = 1'b1;
        drive_push(1'b1, 32'h3F0, 1'b0);
        bus.i_out_ready = 1'b1;
        step();
        flush = 1'b0;
        drive_push(1'b0, 32'h0, 1'b0);
        bus.i_out_ready = 1'b0;
        check("fl_count", 64'(count), 64'd0);
        check("fl_valid", 64'(bus.o_out_valid), 64'd0);
        check("fl_bubble", 64'(bubble), 64'd1);
        check("fl_in_ready", 64'(bus.o_in_ready), 64'd1);
        step();
        check("fl_bubble_clear", 64'(bubble), 64'd0);
        check("fl_count_after", 64'(count), 64'd0);

        // ---- consecutive flushes
        flush = 1'b1;
        step();
        check("fl2_bubble_a", 64'(bubble), 64'd1);
        step();
        check("fl2_bubble_b", 64'(bubble), 64'd1);
        check("fl2_count", 64'(count), 64'd0);
        flush = 1'b0;
        step();
        check("fl2_bubble_clear", 64'(bubble), 64'd0);

        // ---- prediction bit
        drive_push(1'b1, 32'h20, 1'b1);
        step();
        drive_push(1'b1, 32'h24, 1'b0);
        step();
        drive_push(1'b0, 32'h0, 1'b0);
        bus.i_out_ready = 1'b1;
        check("pred_first", 64'(bus.o_out_pred_taken), 64'd1);
        check("pred_first_pc", 64'(bus.o_out_pc), 64'h20);
        step();
        check("pred_second", 64'(bus.o_out_pred_taken), 64'd0);
        check("pred_second_pc", 64'(bus.o_out_pc), 64'h24);
        step();
        check("pred_drained", 64'(count), 64'd0);

        // ---- reset mid-operation (with push, pop and flush also requested)
        bus.i_out_ready = 1'b0;
        drive_push(1'b1, 32'h400, 1'b0);
        step();
        drive_push(1'b1, 32'h404, 1'b0);
        step();
        check("mr_pre_count", 64'(count), 64'd2);
        rst_n = 1'b0;
        flush = 1'b1;
        drive_push(1'b1, 32'h408, 1'b0);
        bus.i_out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        flush = 1'b0;
        drive_push(1'b0, 32'h0, 1'b0);
        check("mr_count", 64'(count), 64'd0);
        check("mr_valid", 64'(bus.o_out_valid), 64'd0);
        check("mr_pc", 64'(bus.o_out_pc), 64'd0);
        check("mr_instr", 64'(bus.o_out_instr), 64'(NOP));
        check("mr_pred", 64'(bus.o_out_pred_taken), 64'd0);
        check("mr_bubble", 64'(bubble), 64'd0);
        check("mr_in_ready", 64'(bus.o_in_ready), 64'd1);
        step();
        check("mr_no_pop_valid", 64'(bus.o_out_valid), 64'd0);
        check("mr_no_pop_count", 64'(count), 64'd0);
        drive_push(1'b1, 32'h500, 1'b0);
        step();
        drive_push(1'b0, 32'h0, 1'b0);
        check("mr_new_count", 64'(count), 64'd1);
        check("mr_new_pc", 64'(bus.o_out_pc), 64'h500);
        step();
        check("mr_new_drained", 64'(count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning PC width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning number of queue entries; legal values are powers of 2 and at least 2.
REQ-003 The block SHALL have parameter NOP_INSTR, default 32'h00000013, meaning the instruction presented when no valid entry is available.
REQ-004 i_clk  input  1  rising-edge clock.
REQ-005 i_reset  input  1  synchronous, active-low reset.
REQ-006 i_flush  input  1  discard all queued entries (redirect from a later stage).
REQ-007 i_in_valid  input  1  IF stage offers an entry.
REQ-008 i_in_pc  input  XLEN  PC of the offered entry.
REQ-009 i_in_instr  input  32  instruction of the offered entry.
REQ-010 i_in_pred_taken  input  1  the IF stage predicted the offered entry taken.
REQ-011 o_in_ready  output  1  the queue can accept an entry this cycle.
REQ-012 o_out_valid  output  1  a head entry is available to ID.
REQ-013 o_out_pc  output  XLEN  head entry PC.
REQ-014 o_out_instr  output  32  head entry instruction.
REQ-015 o_out_pred_taken  output  1  head entry prediction bit.
REQ-016 i_out_ready  input  1  ID consumes the head entry this cycle.
REQ-017 o_count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-018 o_bubble  output  1  high for exactly one cycle following a flush.

Function
REQ-019 Push SHALL occur when i_in_valid=1 and o_in_ready=1; pop SHALL occur when o_out_valid=1 and i_out_ready=1.
REQ-020 o_in_ready SHALL equal (o_count < DEPTH). It is a function of state only and has no combinational dependence on i_out_ready or i_flush.
REQ-021 A push while full (i_in_valid=1, o_in_ready=0) SHALL be ignored, including when a pop happens in the same cycle.
REQ-022 Entries SHALL be popped in push order (FIFO).
REQ-023 The write and read pointers SHALL wrap modulo DEPTH.
REQ-024 An entry pushed in cycle N SHALL be visible at the outputs no earlier than cycle N+1; there is no input-to-output bypass.
REQ-025 A simultaneous push and pop SHALL leave o_count unchanged. A push alone SHALL add 1, and a pop alone SHALL subtract 1.
REQ-026 A pop while empty SHALL not be possible, because o_out_valid=0 when empty; pointers and count SHALL not change.
REQ-027 o_out_valid SHALL equal (o_count != 0).
REQ-028 When empty, the outputs SHALL be o_out_pc=0, o_out_instr=NOP_INSTR and o_out_pred_taken=0. When not empty, they SHALL show the head entry.
REQ-029 A flush SHALL take priority over push and pop in the same cycle. In the next cycle: o_count=0, both pointers=0, the push/pop of the flush cycle discarded, and o_bubble=1.
REQ-030 o_bubble SHALL be 0 in every cycle not immediately following a cycle with i_flush=1 and i_reset=1.
REQ-031 Consecutive flush cycles SHALL keep the queue empty and o_bubble high for each following cycle.
REQ-032 o_in_ready SHALL be 1 in the cycle after a flush.

Reset
REQ-033 When i_reset=0 at a rising edge, the next-cycle state SHALL be: o_count=0, pointers=0, o_out_valid=0, o_out_pc=0, o_out_instr=NOP_INSTR, o_out_pred_taken=0, o_bubble=0 and o_in_ready=1.
REQ-034 Reset SHALL take priority over flush, push and pop.
REQ-035 Reset asserted mid-operation SHALL discard all entries.
REQ-036 Storage array contents SHALL need no reset; only pointers, count and o_bubble are reset.

Verification
REQ-037 Fill/drain: DEPTH=4, i_out_ready=0, push PCs 0x0/0x4/0x8/0xC:
- o_count reaches 4 and o_in_ready=0.
- A fifth push (0x10) is ignored.
- With i_out_ready=1, pops return 0x0, 0x4, 0x8, 0xC in order, then o_out_valid=0 and o_out_instr=0x00000013.
REQ-038 Wrap and throughput: with i_in_valid=1 and i_out_ready=1 for 12 cycles, pushing PCs 0x100+4k:
- Each PC is popped exactly once, in order, with no loss across pointer wrap.
- o_count stays at 1 once the first entry lands.
REQ-039 Full plus simultaneous pop: queue full and i_out_ready=1 with i_in_valid=1 (PC 0x40):
- The head pops and the push is rejected; o_count becomes 3.
- The next cycle the push of 0x40 is accepted.
REQ-040 Flush with push and pop: queue holding 3 entries, with i_flush=1, i_in_valid=1 and i_out_ready=1 in the same cycle:
- Next cycle: o_count=0, o_out_valid=0, o_bubble=1 and o_in_ready=1.
- The cycle after: o_bubble=0.
REQ-041 Prediction bit: push entry PC 0x20 with i_in_pred_taken=1 and PC 0x24 with i_in_pred_taken=0 -> popped o_out_pred_taken sequence is 1 then 0.
REQ-042 Reset mid-operation: queue holding 2 entries with i_reset=0 for one cycle -> all REQ-033 values; subsequent pops produce nothing until new pushes.
